// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: assembles PS/2 set-2 scancode bytes into key events, queues them, pulses game commands
// Ports: CLOCK_50/reset (sync, active-high); received_data/received_data_en byte strobe in;
//        evt_valid/evt_ready/evt_code/evt_extended/evt_break FWFT event head; cmd_* one-cycle
//        command pulses; overflow sticky drop flag.
module ps2_key_decoder #(
  parameter logic [7:0] KEY_HIT   = 8'h33,
  parameter logic [7:0] KEY_STAND = 8'h1B,
  parameter logic [7:0] KEY_DEAL  = 8'h23,
  parameter logic [7:0] KEY_NEW   = 8'h31
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_extended,
  output logic       evt_break,
  output logic       cmd_hit,
  output logic       cmd_stand,
  output logic       cmd_deal,
  output logic       cmd_new,
  output logic       overflow
);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;
  state_t     state_q, state_d;
  logic [2:0] skip_q, skip_d;
  logic [3:0] held_q, held_d, cmd_q, cmd_d, key_match;
  logic [9:0] mem_q [4];
  logic [1:0] wr_q, wr_d, rd_q, rd_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       ev, ev_ext, ev_brk, is_pfx, ignored, pop, push;
  always_comb begin
    is_pfx  = received_data == 8'hE0 || received_data == 8'hF0;
    ignored = received_data inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF};
    state_d = state_q;
    skip_d  = skip_q;
    ev      = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    if (received_data_en)
      case (state_q)
        IDLE: begin
          state_d = received_data == 8'hE0 ? EXT :
                    received_data == 8'hF0 ? BRK :
                    received_data == 8'hE1 ? SKIP : IDLE;
          skip_d  = received_data == 8'hE1 ? 3'd7 : skip_q;
          ev      = !is_pfx && received_data != 8'hE1 && !ignored;
        end
        EXT: begin
          state_d = received_data == 8'hF0 ? EXT_BRK : received_data == 8'hE0 ? EXT : IDLE;
          ev      = !is_pfx;
          ev_ext  = 1'b1;
        end
        BRK: begin
          state_d = IDLE;
          ev      = !is_pfx;
          ev_brk  = 1'b1;
        end
        EXT_BRK: begin
          state_d = IDLE;
          ev      = !is_pfx;
          ev_ext  = 1'b1;
          ev_brk  = 1'b1;
        end
        SKIP: begin
          skip_d  = skip_q - 3'd1;
          state_d = skip_q <= 3'd1 ? IDLE : SKIP;
        end
        default: state_d = IDLE;
      endcase
  end
  // Held flags suppress typematic repeats; extended codes never touch them.
  always_comb begin
    key_match = {received_data == KEY_NEW, received_data == KEY_DEAL,
                 received_data == KEY_STAND, received_data == KEY_HIT};
    cmd_d     = '0;
    held_d    = held_q;
    if (ev && !ev_ext) begin
      cmd_d  = ev_brk ? 4'b0 : key_match & ~held_q;
      held_d = ev_brk ? held_q & ~key_match : held_q | key_match;
    end
  end
  // A pop frees the slot in the same cycle, so a push to a full FIFO with a pop is kept.
  always_comb begin
    evt_valid = cnt_q != 3'd0;
    pop       = evt_valid && evt_ready;
    push      = ev && (!cnt_q[2] || pop);
    wr_d      = wr_q + 2'(push);
    rd_d      = rd_q + 2'(pop);
    cnt_d     = cnt_q + 3'(push) - 3'(pop);
    ovf_d     = ovf_q || (ev && cnt_q[2] && !pop);
    {evt_extended, evt_break, evt_code} = evt_valid ? mem_q[rd_q] : 10'd0;
    {cmd_new, cmd_deal, cmd_stand, cmd_hit} = cmd_q;
    overflow  = ovf_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      skip_q  <= '0;
      held_q  <= '0;
      cmd_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      held_q  <= held_d;
      cmd_q   <= cmd_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (push) mem_q[wr_q] <= {ev_ext, ev_brk, received_data};
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: scoreboard bench with a prefix-accumulating reference model
module tb_ps2_key_decoder;
  logic       clk = 1'b0, reset = 1'b1, en = 1'b0, ready = 1'b0;
  logic [7:0] data = 8'h00;
  logic       evt_valid, evt_extended, evt_break, cmd_hit, cmd_stand, cmd_deal, cmd_new, overflow;
  logic [7:0] evt_code;

  ps2_key_decoder dut (
    .CLOCK_50(clk), .reset(reset), .received_data(data), .received_data_en(en),
    .evt_valid(evt_valid), .evt_ready(ready), .evt_code(evt_code),
    .evt_extended(evt_extended), .evt_break(evt_break),
    .cmd_hit(cmd_hit), .cmd_stand(cmd_stand), .cmd_deal(cmd_deal), .cmd_new(cmd_new),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int         n_chk = 0, n_fail = 0;
  logic [9:0] exp_q[$];
  int         occ = 0, skip = 0;
  bit         ovf_m = 0, pend_ext = 0, pend_brk = 0, started = 0, just_reset = 0;
  bit   [3:0] held = 0, cmd_exp = 0;
  logic [7:0] keys [4] = '{8'h33, 8'h1B, 8'h23, 8'h31};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic emit(input bit x, input bit b, input logic [7:0] c);
    if (occ < 4) begin
      occ++;
      exp_q.push_back({x, b, c});
    end else ovf_m = 1;
    if (!x)
      for (int i = 0; i < 4; i++)
        if (c == keys[i]) begin
          if (b) held[i] = 0;
          else if (!held[i]) begin
            held[i]    = 1;
            cmd_exp[i] = 1;
          end
        end
  endtask

  task automatic model_byte(input logic [7:0] d);
    if (skip > 0) skip--;
    else if (pend_brk) begin
      if (d != 8'hE0 && d != 8'hF0) emit(pend_ext, 1, d);
      pend_ext = 0;
      pend_brk = 0;
    end else if (pend_ext) begin
      if (d == 8'hF0) pend_brk = 1;
      else if (d != 8'hE0) begin
        emit(1, 0, d);
        pend_ext = 0;
      end
    end else if (d == 8'hE0) pend_ext = 1;
    else if (d == 8'hF0) pend_brk = 1;
    else if (d == 8'hE1) skip = 7;
    else if (!(d inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) emit(0, 0, d);
  endtask

  always @(posedge clk) begin
    started    = 1;
    just_reset = reset;
    cmd_exp    = 0;
    if (reset) begin
      occ = 0; ovf_m = 0; held = 0; skip = 0; pend_ext = 0; pend_brk = 0;
      exp_q.delete();
    end else begin
      if (occ > 0 && ready) occ--;
      if (en) model_byte(data);
    end
  end

  always @(negedge clk) if (started) begin
    check("evt_valid", 32'(evt_valid), 32'(occ > 0));
    check("cmd", 32'({cmd_new, cmd_deal, cmd_stand, cmd_hit}), 32'(cmd_exp));
    check("overflow", 32'(overflow), 32'(ovf_m));
    if (just_reset) check("reset_evt", 32'({evt_extended, evt_break, evt_code}), 32'd0);
    if (evt_valid && exp_q.size() > 0)
      check("evt_head", 32'({evt_extended, evt_break, evt_code}), 32'(exp_q[0]));
    if (evt_valid && ready) begin
      if (exp_q.size() == 0) check("unexpected_evt", 32'({evt_extended, evt_break, evt_code}), 32'h400);
      else void'(exp_q.pop_front());
    end
  end

  task automatic cyc(input bit e, input logic [7:0] d, input bit r);
    en = e; data = d; ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1, d, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 1);
  endtask

  logic [7:0] s1[] = '{8'h33, 8'hF0, 8'h33};
  logic [7:0] s2[] = '{8'h1B, 8'h1B, 8'h1B, 8'hF0, 8'h1B, 8'h1B};
  logic [7:0] s3[] = '{8'hE0, 8'h33, 8'hE0, 8'hF0, 8'h33};
  logic [7:0] s4[] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h23};
  logic [7:0] s5[] = '{8'h15, 8'h16, 8'h1C, 8'h24, 8'h2B, 8'h34};

  initial begin
    logic [7:0] b;
    reset = 1;
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    reset = 0;
    idle(2);
    foreach (s1[i]) send(s1[i]);
    idle(3);
    foreach (s2[i]) send(s2[i]);
    idle(3);
    foreach (s3[i]) send(s3[i]);
    idle(3);
    foreach (s4[i]) send(s4[i]);
    idle(4);
    foreach (s5[i]) cyc(1, s5[i], 0);
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    idle(4);
    cyc(0, 8'h00, 0);
    send(8'hE0);
    send(8'hF0);
    reset = 1;
    cyc(0, 8'h00, 1);
    reset = 0;
    send(8'h31);
    idle(3);
    for (int n = 0; n < 3000; n++) begin
      case ($urandom % 12)
        0: b = 8'h33;
        1: b = 8'h1B;
        2: b = 8'h23;
        3: b = 8'h31;
        4: b = 8'hE0;
        5: b = 8'hF0;
        6: b = 8'hE1;
        7: b = 8'hAA;
        8: b = 8'hFA;
        default: b = 8'($urandom);
      endcase
      reset = ($urandom % 400) == 0;
      cyc(($urandom % 3) != 0, b, ($urandom % 4) != 0);
    end
    reset = 0;
    idle(10);
    check("drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Downstream consumer of the PS/2 controller's received byte stream. Assembles PS/2 set-2 scancode sequences (0xE0 extended prefix, 0xF0 break prefix, 0xE1 pause sequence) into complete key events, buffers them in a 4-entry FIFO with a valid/ready handshake, and emits one-cycle game command pulses (hit, stand, deal, new) with typematic-repeat suppression. It sits between the PS2_Controller instance and the blackjack game control FSM.

## Interface
Parameters:
- KEY_HIT, default 8'h33, make code for hit ('H')
- KEY_STAND, default 8'h1B, make code for stand ('S')
- KEY_DEAL, default 8'h23, make code for deal ('D')
- KEY_NEW, default 8'h31, make code for new game ('N')

Ports:
- CLOCK_50  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- received_data  in  8  byte from the PS/2 controller
- received_data_en  in  1  one-cycle strobe; received_data is valid this cycle
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts the head event this cycle
- evt_code  out  8  scancode of the head event (prefixes stripped)
- evt_extended  out  1  head event was 0xE0-prefixed
- evt_break  out  1  head event is a release (1) or press (0)
- cmd_hit, cmd_stand, cmd_deal, cmd_new  out  1 each  one-cycle command pulses
- overflow  out  1  sticky: an event was dropped because the FIFO was full

## Operation
- Decoder FSM, advances only on received_data_en:
  - IDLE: 0xE0 -> EXT; 0xF0 -> BRK; 0xE1 -> SKIP (counter loaded with 7); 0x00/0xAA/0xFA/0xFE/0xFF -> ignored, stay IDLE; other byte -> make event {ext=0, brk=0}, stay IDLE.
  - EXT: 0xF0 -> EXT_BRK; 0xE0 -> stay EXT; other -> make event {ext=1, brk=0}, -> IDLE.
  - BRK: any byte other than 0xE0/0xF0 -> break event {ext=0, brk=1}, -> IDLE; 0xE0 or 0xF0 -> protocol error, discard, -> IDLE.
  - EXT_BRK: any byte other than 0xE0/0xF0 -> break event {ext=1, brk=1}, -> IDLE; 0xE0 or 0xF0 -> discard, -> IDLE.
  - SKIP: decrements the counter on each strobe; the strobe that brings the counter from 1 to 0 -> IDLE. No events are generated for the pause sequence.
- Every generated event is pushed to the FIFO, typematic repeats included (each repeated make is a separate event).
- Command logic, non-extended events only: four held flags, one per command key.
  - Make of a command key with its held flag clear: pulse the matching cmd_* and set the flag.
  - Make with the flag set (repeat): no pulse.
  - Break clears the flag.
  - Extended events with matching codes never affect flags or pulses.
- FIFO: 4 entries x 10 bits {ext, brk, code}, first-word-fall-through; head drives evt_*. Pop when evt_valid && evt_ready.
  - Push while full with no pop the same cycle: event dropped, overflow set. Command pulses are still generated.
  - Push and pop in the same cycle while full: both take effect; no drop.
  - Push and pop in the same cycle while empty: the push is stored; evt_valid rises next cycle.
- overflow is cleared only by reset.

## Timing
- Reset values: FSM IDLE, SKIP counter 0, held flags 0, FIFO empty, evt_valid 0, evt_code 0, evt_extended 0, evt_break 0, all cmd_* 0, overflow 0.
- Reset takes priority over a simultaneous strobe. Reset mid-sequence (EXT/BRK/SKIP) abandons the partial sequence with no event.
- Strobe on the final byte at edge N: the event is written at edge N. evt_valid and evt_* are valid after edge N (1-cycle latency). cmd_* is high for exactly the one cycle after edge N.
- evt_* hold stable while evt_valid && !evt_ready.
- Back-to-back strobes on consecutive cycles must be accepted; the FSM sustains one byte per cycle.

## Test plan
- Byte stream 33, F0, 33 -> cmd_hit one pulse one cycle after the first strobe; FIFO events {33,ext0,brk0} then {33,ext0,brk1}; no other cmd pulses.
- Byte stream 1B, 1B, 1B, F0, 1B, 1B -> exactly two cmd_stand pulses (the first make and the make after the break); 5 events pushed.
- Byte stream E0, 33, E0, F0, 33 -> events {33,ext1,brk0} and {33,ext1,brk1}; no cmd_hit; hit held flag stays 0.
- Byte stream E1, 14, 77, E1, F0, 14, F0, 77, then 23 -> only {23,0,0} is queued and cmd_deal pulses once.
- evt_ready held 0 while 6 make events arrive -> 4 queued, overflow=1, head is the first event. Then ready=1 for 4 cycles -> events drain in order, evt_valid=0 afterwards, overflow still 1.
- Bytes E0, F0, then reset asserted for 1 cycle, then 31 -> no extended event; {31,0,0} queued; cmd_new pulses; all outputs at reset values during the cycle after reset.
